// File: rtl/piano_pkg.sv
// Shared definitions for the piano controllers: state encoding and debug width.
package piano_pkg;

   localparam int DB_ESTADO_W = 4;

   typedef enum logic [DB_ESTADO_W-1:0] {
      ST_IDLE        = 4'd0,
      ST_INICIA      = 4'd1,
      ST_MOSTRA      = 4'd2,
      ST_PROX_MOSTRA = 4'd3,
      ST_FIM_MOSTRA  = 4'd4,
      ST_ESPERA      = 4'd5,
      ST_COMPARA     = 4'd6,
      ST_FEEDBACK    = 4'd7,
      ST_PROX_NOTA   = 4'd8,
      ST_FIM_RODADA  = 4'd9,
      ST_ERRO        = 4'd10,
      ST_REPETE      = 4'd11,
      ST_ACERTOU     = 4'd12,
      ST_FALHOU      = 4'd13
   } estado_t;

endpackage

// File: rtl/controle_aprendizado.sv
// Progressive "learn the song" controller: replays notes 0..r, then checks the
// player's repetition, growing the round on success and counting errors.
//
// state          | meaning
// IDLE        0  | waiting for start
// INICIA      1  | clear counters, timers, register and error count
// MOSTRA      2  | play memory note, feedback timer running
// PROX_MOSTRA 3  | advance address during replay
// FIM_MOSTRA  4  | replay done, prepare for input
// ESPERA      5  | wait for a key, timeout running
// COMPARA     6  | note register settles before comparison
// FEEDBACK    7  | echo played note until timer done and key released
// PROX_NOTA   8  | advance to next expected note
// FIM_RODADA  9  | round complete: grow round or win
// ERRO       10  | count an error
// REPETE     11  | replay the same round
// ACERTOU    12  | song learned
// FALHOU     13  | too many errors
module controle_aprendizado
   import piano_pkg::*;
#(
   parameter int ERRO      = 3,
   parameter int MAX_ERROS = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   press_enter,
   input  logic                   nota_feita,
   input  logic                   nota_correta,
   input  logic                   enderecoIgualRodada,
   input  logic                   fim_musica,
   input  logic                   fimCR,
   input  logic                   fimTF,
   input  logic                   fimTempo,
   output logic                   zeraR,
   output logic                   registraR,
   output logic                   zeraC,
   output logic                   contaC,
   output logic                   zeraCR,
   output logic                   contaCR,
   output logic                   zeraTF,
   output logic                   contaTF,
   output logic                   zeraTempo,
   output logic                   contaTempo,
   output logic                   leds_mem,
   output logic                   ativa_leds,
   output logic                   toca,
   output logic [ERRO-1:0]        erros,
   output logic                   pronto,
   output logic                   acertou,
   output logic                   falhou,
   output logic [DB_ESTADO_W-1:0] db_estado
);

   localparam logic [ERRO-1:0] ERROS_SAT = '1;
   localparam logic [ERRO-1:0] ERROS_LIM = ERRO'(MAX_ERROS - 1);

   estado_t estado, estado_prox;

   // erros clears on entry to INICIA so it already reads 0 while in INICIA
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= ST_IDLE;
         erros  <= '0;
      end else begin
         estado <= estado_prox;
         if (estado_prox == ST_INICIA)
            erros <= '0;
         else if (estado == ST_ERRO && erros != ERROS_SAT)
            erros <= erros + ERRO'(1);
      end
   end

   always_comb begin
      estado_prox = ST_IDLE;
      case (estado)
         ST_IDLE:        estado_prox = press_enter ? ST_INICIA : ST_IDLE;
         ST_INICIA:      estado_prox = ST_MOSTRA;
         ST_MOSTRA:      estado_prox = !fimTF ? ST_MOSTRA :
                                       (enderecoIgualRodada ? ST_FIM_MOSTRA : ST_PROX_MOSTRA);
         ST_PROX_MOSTRA: estado_prox = ST_MOSTRA;
         ST_FIM_MOSTRA:  estado_prox = ST_ESPERA;
         ST_ESPERA:      estado_prox = nota_feita ? ST_COMPARA :
                                       (fimTempo ? ST_ERRO : ST_ESPERA);
         ST_COMPARA:     estado_prox = nota_correta ? ST_FEEDBACK : ST_ERRO;
         ST_FEEDBACK:    estado_prox = !(fimTF && !nota_feita) ? ST_FEEDBACK :
                                       (enderecoIgualRodada ? ST_FIM_RODADA : ST_PROX_NOTA);
         ST_PROX_NOTA:   estado_prox = ST_ESPERA;
         ST_FIM_RODADA:  estado_prox = (fim_musica || fimCR) ? ST_ACERTOU : ST_MOSTRA;
         ST_ERRO:        estado_prox = (erros == ERROS_LIM) ? ST_FALHOU : ST_REPETE;
         ST_REPETE:      estado_prox = ST_MOSTRA;
         ST_ACERTOU:     estado_prox = press_enter ? ST_INICIA : ST_ACERTOU;
         ST_FALHOU:      estado_prox = press_enter ? ST_INICIA : ST_FALHOU;
         default:        estado_prox = ST_IDLE;
      endcase
   end

   always_comb begin
      zeraR      = 1'b0;
      registraR  = 1'b0;
      zeraC      = 1'b0;
      contaC     = 1'b0;
      zeraCR     = 1'b0;
      contaCR    = 1'b0;
      zeraTF     = 1'b0;
      contaTF    = 1'b0;
      zeraTempo  = 1'b0;
      contaTempo = 1'b0;
      leds_mem   = 1'b0;
      ativa_leds = 1'b0;
      toca       = 1'b0;
      pronto     = 1'b0;
      acertou    = 1'b0;
      falhou     = 1'b0;
      case (estado)
         ST_INICIA: begin
            zeraC     = 1'b1;
            zeraCR    = 1'b1;
            zeraR     = 1'b1;
            zeraTF    = 1'b1;
            zeraTempo = 1'b1;
         end
         ST_MOSTRA: begin
            leds_mem   = 1'b1;
            ativa_leds = 1'b1;
            toca       = 1'b1;
            contaTF    = 1'b1;
         end
         ST_PROX_MOSTRA: begin
            contaC = 1'b1;
            zeraTF = 1'b1;
         end
         ST_FIM_MOSTRA, ST_PROX_NOTA: begin
            zeraC     = (estado == ST_FIM_MOSTRA);
            contaC    = (estado == ST_PROX_NOTA);
            zeraTF    = 1'b1;
            zeraTempo = 1'b1;
            zeraR     = 1'b1;
         end
         ST_ESPERA: begin
            contaTempo = 1'b1;
            registraR  = 1'b1;
         end
         ST_FEEDBACK: begin
            ativa_leds = 1'b1;
            toca       = 1'b1;
            contaTF    = 1'b1;
         end
         // round growth strobes only on the replay branch, never on a win
         ST_FIM_RODADA: begin
            if (!(fim_musica || fimCR)) begin
               contaCR = 1'b1;
               zeraC   = 1'b1;
               zeraTF  = 1'b1;
            end
         end
         ST_ERRO: begin
            zeraTF = 1'b1;
            zeraR  = 1'b1;
         end
         ST_REPETE: begin
            zeraC  = 1'b1;
            zeraTF = 1'b1;
         end
         ST_ACERTOU: begin
            pronto  = 1'b1;
            acertou = 1'b1;
         end
         ST_FALHOU: begin
            pronto = 1'b1;
            falhou = 1'b1;
         end
         default: ;
      endcase
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_controle_aprendizado.sv
// Directed bench for controle_aprendizado: expected state, error count and
// strobe vector are queued per step and compared one cycle later.
module tb_controle_aprendizado;

   localparam int IDLE = 0, INICIA = 1, MOSTRA = 2, PROX_MOSTRA = 3, FIM_MOSTRA = 4,
                  ESPERA = 5, COMPARA = 6, FEEDBACK = 7, PROX_NOTA = 8, FIM_RODADA = 9,
                  ERRO_S = 10, REPETE = 11, ACERTOU = 12, FALHOU = 13;

   logic clock = 1'b0;
   logic reset;
   logic press_enter, nota_feita, nota_correta, enderecoIgualRodada;
   logic fim_musica, fimCR, fimTF, fimTempo;
   logic zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF;
   logic zeraTempo, contaTempo, leds_mem, ativa_leds, toca, pronto, acertou, falhou;
   logic [2:0] erros;
   logic [3:0] db_estado;

   typedef struct {
      string      tag;
      int         st;
      logic [2:0] e;
      logic [15:0] o;
   } exp_t;

   exp_t sb[$];
   int n_assert = 0;
   int n_fail   = 0;

   wire [15:0] outs_obs = {zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF,
                           zeraTempo, contaTempo, leds_mem, ativa_leds, toca, pronto, acertou, falhou};

   controle_aprendizado #(.ERRO(3), .MAX_ERROS(3)) dut (
      .clock(clock), .reset(reset), .press_enter(press_enter), .nota_feita(nota_feita),
      .nota_correta(nota_correta), .enderecoIgualRodada(enderecoIgualRodada),
      .fim_musica(fim_musica), .fimCR(fimCR), .fimTF(fimTF), .fimTempo(fimTempo),
      .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
      .zeraCR(zeraCR), .contaCR(contaCR), .zeraTF(zeraTF), .contaTF(contaTF),
      .zeraTempo(zeraTempo), .contaTempo(contaTempo), .leds_mem(leds_mem),
      .ativa_leds(ativa_leds), .toca(toca), .erros(erros), .pronto(pronto),
      .acertou(acertou), .falhou(falhou), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // bit order matches outs_obs
   function automatic logic [15:0] outs_for(int st, logic fimx);
      logic [15:0] o;
      o = '0;
      case (st)
         INICIA:      begin o[13] = 1; o[11] = 1; o[15] = 1; o[9] = 1; o[7] = 1; end
         MOSTRA:      begin o[5] = 1; o[4] = 1; o[3] = 1; o[8] = 1; end
         PROX_MOSTRA: begin o[12] = 1; o[9] = 1; end
         FIM_MOSTRA:  begin o[13] = 1; o[9] = 1; o[7] = 1; o[15] = 1; end
         ESPERA:      begin o[6] = 1; o[14] = 1; end
         FEEDBACK:    begin o[4] = 1; o[3] = 1; o[8] = 1; end
         PROX_NOTA:   begin o[12] = 1; o[9] = 1; o[7] = 1; o[15] = 1; end
         FIM_RODADA:  if (!fimx) begin o[10] = 1; o[13] = 1; o[9] = 1; end
         ERRO_S:      begin o[9] = 1; o[15] = 1; end
         REPETE:      begin o[13] = 1; o[9] = 1; end
         ACERTOU:     begin o[2] = 1; o[1] = 1; end
         FALHOU:      begin o[2] = 1; o[0] = 1; end
         default:     o = '0;
      endcase
      return o;
   endfunction

   task automatic push(string tag, int st, int e);
      exp_t x;
      x.tag = tag;
      x.st  = st;
      x.e   = 3'(e);
      x.o   = outs_for(st, fim_musica | fimCR);
      sb.push_back(x);
   endtask

   task automatic check();
      exp_t x;
      x = sb.pop_front();
      n_assert++;
      assert (db_estado === 4'(x.st)) else begin
         n_fail++;
         $error("FAIL %s db_estado observed=%0d expected=%0d", x.tag, db_estado, x.st);
      end
      n_assert++;
      assert (erros === x.e) else begin
         n_fail++;
         $error("FAIL %s erros observed=%0d expected=%0d", x.tag, erros, x.e);
      end
      n_assert++;
      assert (outs_obs === x.o) else begin
         n_fail++;
         $error("FAIL %s strobes observed=%b expected=%b", x.tag, outs_obs, x.o);
      end
   endtask

   task automatic now(string tag, int st, int e);
      push(tag, st, e);
      check();
   endtask

   task automatic step(string tag, int st, int e);
      push(tag, st, e);
      @(posedge clock);
      #1;
      check();
   endtask

   initial begin
      reset = 1'b1;
      press_enter = 0; nota_feita = 0; nota_correta = 0; enderecoIgualRodada = 0;
      fim_musica = 0; fimCR = 0; fimTF = 0; fimTempo = 0;
      #3;
      now("in_reset", IDLE, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      now("post_reset", IDLE, 0);
      step("idle_hold", IDLE, 0);

      // start: 0 -> 1 -> 2, zeraCR for one cycle only
      press_enter = 1;
      step("start_inicia", INICIA, 0);
      press_enter = 0;
      step("start_mostra", MOSTRA, 0);
      press_enter = 1;
      step("mostra_ignores_enter", MOSTRA, 0);
      press_enter = 0;

      // round 0
      fimTF = 1; enderecoIgualRodada = 1;
      step("r0_fim_mostra", FIM_MOSTRA, 0);
      fimTF = 0;
      step("r0_espera", ESPERA, 0);
      step("r0_espera_hold", ESPERA, 0);
      nota_feita = 1; nota_correta = 1;
      step("r0_compara", COMPARA, 0);
      step("r0_feedback", FEEDBACK, 0);
      nota_feita = 0; fimTF = 1;
      step("r0_fim_rodada", FIM_RODADA, 0);
      fimTF = 0;
      step("r0_next_mostra", MOSTRA, 0);

      // round 1: two-note replay, then timeout
      fimTF = 1; enderecoIgualRodada = 0;
      step("r1_prox_mostra", PROX_MOSTRA, 0);
      fimTF = 0;
      step("r1_mostra2", MOSTRA, 0);
      fimTF = 1; enderecoIgualRodada = 1;
      step("r1_fim_mostra", FIM_MOSTRA, 0);
      fimTF = 0;
      step("r1_espera", ESPERA, 0);
      fimTempo = 1;
      step("timeout_erro", ERRO_S, 0);
      fimTempo = 0;
      step("timeout_repete", REPETE, 1);
      step("timeout_mostra", MOSTRA, 1);

      // first wrong note
      fimTF = 1;
      step("w1_fim_mostra", FIM_MOSTRA, 1);
      fimTF = 0;
      step("w1_espera", ESPERA, 1);
      nota_feita = 1; nota_correta = 0;
      step("w1_compara", COMPARA, 1);
      nota_feita = 0;
      step("w1_erro", ERRO_S, 1);
      step("w1_repete", REPETE, 2);
      step("w1_mostra", MOSTRA, 2);

      // second wrong note reaches the limit
      fimTF = 1;
      step("w2_fim_mostra", FIM_MOSTRA, 2);
      fimTF = 0;
      step("w2_espera", ESPERA, 2);
      nota_feita = 1;
      step("w2_compara", COMPARA, 2);
      nota_feita = 0;
      step("w2_erro", ERRO_S, 2);
      step("w2_falhou", FALHOU, 3);
      step("falhou_hold", FALHOU, 3);
      press_enter = 1;
      step("restart_inicia", INICIA, 0);
      press_enter = 0;
      step("restart_mostra", MOSTRA, 0);

      // simultaneous key and timeout: key wins
      fimTF = 1;
      step("g2_fim_mostra", FIM_MOSTRA, 0);
      fimTF = 0;
      step("g2_espera", ESPERA, 0);
      nota_feita = 1; fimTempo = 1; nota_correta = 1;
      step("both_compara", COMPARA, 0);
      fimTempo = 0;
      step("g2_feedback", FEEDBACK, 0);
      fimTF = 1;
      for (int i = 0; i < 10; i++) step("key_held", FEEDBACK, 0);
      nota_feita = 0; fim_musica = 1;
      step("g2_fim_rodada", FIM_RODADA, 0);
      fimTF = 0;
      step("acertou", ACERTOU, 0);
      fim_musica = 0;
      step("acertou_hold", ACERTOU, 0);

      // asynchronous reset mid-cycle
      #3;
      reset = 1'b1;
      #1;
      now("async_reset", IDLE, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      step("after_reset_idle", IDLE, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_aprendizado.md
# controle_aprendizado

Moore controller that sequences the piano datapath in progressive "learn the song" mode. Each round it replays memory notes 0..r on LEDs and buzzer, then waits for the player to repeat them. On success the round grows by one note; wrong notes and timeouts are counted as errors. It sits beside the datapath, consuming its condition flags and driving its counter, timer, register and display control strobes.

## Interface
- `ERRO`, 3: width of the error counter output.
- `MAX_ERROS`, 3: error count that ends the game in failure; legal range 1..2^ERRO-1.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high; forces `IDLE` and clears `erros`.
- `press_enter` in 1: one-cycle start pulse, already edge-detected.
- `nota_feita` in 1: some debounced key is held.
- `nota_correta` in 1: registered note equals memory note.
- `enderecoIgualRodada` in 1: address counter equals round counter.
- `fim_musica` in 1: current memory address holds the song's last note.
- `fimCR` in 1: round counter at its maximum.
- `fimTF` in 1: 0.5 s feedback timer done.
- `fimTempo` in 1: 5 s timeout done.
- `zeraR`, `registraR`, `zeraC`, `contaC`, `zeraCR`, `contaCR`, `zeraTF`, `contaTF`, `zeraTempo`, `contaTempo` out 1 each: datapath strobes.
- `leds_mem` out 1: 1 selects the memory note for LEDs/buzzer; 0 selects the played note.
- `ativa_leds`, `toca` out 1: enable the LED decoder and the buzzer.
- `erros` out ERRO: saturating error count.
- `pronto`, `acertou`, `falhou` out 1: game-finished flags.
- `db_estado` out 4: current state code.

## Operation
All outputs are decoded from the state register only. States and their asserted outputs:
- `IDLE` (0): nothing asserted. On `press_enter` → `INICIA`.
- `INICIA` (1): assert `zeraC`, `zeraCR`, `zeraR`, `zeraTF`, `zeraTempo`; clear `erros`. → `MOSTRA`.
- `MOSTRA` (2): assert `leds_mem`, `ativa_leds`, `toca`, `contaTF`. On `fimTF`: → `FIM_MOSTRA` if `enderecoIgualRodada`, else → `PROX_MOSTRA`.
- `PROX_MOSTRA` (3): assert `contaC`, `zeraTF`. → `MOSTRA`.
- `FIM_MOSTRA` (4): assert `zeraC`, `zeraTF`, `zeraTempo`, `zeraR`. → `ESPERA`.
- `ESPERA` (5): assert `contaTempo`, `registraR`.
  - On `nota_feita` → `COMPARA`.
  - Else on `fimTempo` → `ERRO`.
  - If both occur in the same cycle, `nota_feita` wins.
- `COMPARA` (6): nothing asserted. → `FEEDBACK` if `nota_correta`, else → `ERRO`.
- `FEEDBACK` (7): assert `ativa_leds`, `toca`, `contaTF` (`leds_mem`=0). Leave only when `fimTF` & !`nota_feita`:
  - → `FIM_RODADA` if `enderecoIgualRodada`, else → `PROX_NOTA`.
  - While the key is still held after `fimTF`, stay in the state; the timer output stays saturated.
- `PROX_NOTA` (8): assert `contaC`, `zeraTF`, `zeraTempo`, `zeraR`. → `ESPERA`.
- `FIM_RODADA` (9):
  - If `fim_musica` | `fimCR` → `ACERTOU`.
  - Else assert `contaCR`, `zeraC`, `zeraTF` → `MOSTRA`.
  - The `contaCR`/`zeraC` strobes apply only on the `MOSTRA` branch.
- `ERRO` (10): assert `zeraTF`, `zeraR`; `erros` += 1, saturating at 2^ERRO-1.
  - If the pre-increment value is `MAX_ERROS`-1 → `FALHOU`.
  - Else → `REPETE`.
- `REPETE` (11): assert `zeraC`, `zeraTF`. → `MOSTRA`. The same round is replayed and the round counter is untouched.
- `ACERTOU` (12): assert `pronto`, `acertou`. On `press_enter` → `INICIA`.
- `FALHOU` (13): assert `pronto`, `falhou`. On `press_enter` → `INICIA`.
- Codes 14–15: illegal; the next state is `IDLE`.

## Timing
- Reset values: state `IDLE`, `erros`=0, every 1-bit output 0, `db_estado`=0.
- Asynchronous reset is honoured in any state, including mid-round; there is no pending strobe afterwards.
- From `press_enter` sampled high in `IDLE`: `INICIA` on cycle +1, `MOSTRA` on cycle +2.
- Transient states (`INICIA`, `PROX_MOSTRA`, `FIM_MOSTRA`, `COMPARA`, `PROX_NOTA`, `FIM_RODADA`, `ERRO`, `REPETE`) last exactly one cycle.
- `COMPARA` exists because the datapath note register loads on the edge of `nota_feita`. `nota_correta` is valid one cycle after the `ESPERA`→`COMPARA` transition.
- `erros` updates on the clock edge that leaves `ERRO`.
- `press_enter` outside `IDLE`, `ACERTOU` and `FALHOU` is ignored.

## Structure
- Shared package `piano_pkg`: state type with the 4-bit codes above, `DB_ESTADO_W = 4`.
- No sub-modules: one sequential block for state and `erros`, one combinational block for next state and outputs.

## Test plan
- Reset with `ERRO`=3, `MAX_ERROS`=3, then `press_enter` → `db_estado` 0→1→2; `zeraCR`=1 for exactly one cycle.
- Round 0: `fimTF` in `MOSTRA` with `enderecoIgualRodada`=1 → `FIM_MOSTRA`, then `ESPERA`. Set `nota_feita`=1, `nota_correta`=1 → `COMPARA`, `FEEDBACK`. Release key and assert `fimTF` → `FIM_RODADA`, then `MOSTRA` with `contaCR`=1 for one cycle.
- `ESPERA` with `fimTempo`=1 and `nota_feita`=0 → `ERRO`, `erros`=1, then `REPETE`, `MOSTRA`; `contaCR` never asserted.
- Three wrong notes (`nota_correta`=0) → `erros` 1, 2, then `FALHOU` with `pronto`=`falhou`=1 and `erros`=3. `press_enter` → `INICIA`, `erros`=0.
- `nota_feita` and `fimTempo` high in the same `ESPERA` cycle → `COMPARA`, not `ERRO`. Key held 10 cycles past `fimTF` in `FEEDBACK` → stays in state 7.
- `fim_musica`=1 in `FIM_RODADA` → `ACERTOU`. Asserting `reset` two cycles later gives `db_estado`=0 and all outputs 0 immediately.
